// File: rtl/fpga_obi_ram.sv
// fpga_obi_ram: dual-port on-chip RAM behind the cv32e40p OBI ports.
// The instruction port is read-only and the data port is read/write with byte enables. Both share one true-dual-port BRAM.

module fpga_obi_ram_rsp #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hs_i,
  input  logic        oor_i,
  input  logic [31:0] ram_q_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  logic vld1_q;
  logic zero1_q;

  // The zero flags are loaded only together with new read data. Because of this, rdata holds between responses.
  // The flags reset to 1, so rdata reads 0 out of reset without resetting the BRAM data registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld1_q  <= 1'b0;
      zero1_q <= 1'b1;
    end else begin
      vld1_q <= hs_i;
      if (hs_i) zero1_q <= oor_i;
    end
  end

  if (READ_LAT == 1) begin : g_lat1
    assign rvalid_o = vld1_q;
    assign rdata_o  = zero1_q ? 32'h0 : ram_q_i;
  end else begin : g_lat2
    logic        vld2_q;
    logic        zero2_q;
    logic [31:0] data2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld2_q  <= 1'b0;
        zero2_q <= 1'b1;
      end else begin
        vld2_q <= vld1_q;
        if (vld1_q) zero2_q <= zero1_q;
      end
    end

    // BRAM output register: it has an enable but no reset, so it can be absorbed into the block.
    always_ff @(posedge clk_i) begin
      if (vld1_q) data2_q <= ram_q_i;
    end

    assign rvalid_o = vld2_q;
    assign rdata_o  = zero2_q ? 32'h0 : data2_q;
  end

endmodule

module fpga_obi_ram #(
  parameter int unsigned MEM_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        oor_o
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) << 2;

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
    $error("fpga_obi_ram: READ_LAT must be 1 or 2");
  end
  if (MEM_WORDS == 0 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_mem_words
    $error("fpga_obi_ram: MEM_WORDS must be a power of two");
  end

  logic          instr_hs, data_hs;
  logic [31:0]   instr_off, data_off;
  logic          instr_in, data_in;
  logic [AW-1:0] instr_idx, data_idx;
  logic [31:0]   instr_ram_q, data_ram_q;
  logic          oor_q;
  logic [3:0]    unused_off_lsb;

  // The block never stalls. A grant is simply the request, masked while reset is asserted.
  assign instr_gnt_o = instr_req_i & rst_ni;
  assign data_gnt_o  = data_req_i & rst_ni;
  assign instr_hs    = instr_req_i & instr_gnt_o;
  assign data_hs     = data_req_i & data_gnt_o;

  // Range checks use the offset from the base. This also covers addresses below BASE_ADDR, which wrap to large offsets.
  assign instr_off      = instr_addr_i - BASE_ADDR;
  assign data_off       = data_addr_i - BASE_ADDR;
  assign instr_in       = instr_off < MEM_BYTES;
  assign data_in        = data_off < MEM_BYTES;
  assign instr_idx      = instr_off[AW+1:2];
  assign data_idx       = data_off[AW+1:2];
  assign unused_off_lsb = {instr_off[1:0], data_off[1:0]};

  logic [31:0] mem [MEM_WORDS];

  // NOTE: the array has no reset and is written with non-blocking byte-lane assignments. This is what lets
  // synthesis map it onto a byte-write-enable BRAM. The non-blocking read sees the pre-write value (read-first).
  always_ff @(posedge clk_i) begin
    if (instr_hs) instr_ram_q <= mem[instr_idx];
  end

  always_ff @(posedge clk_i) begin
    if (data_hs) begin
      if (data_we_i && data_in) begin
        for (int k = 0; k < 4; k++) begin
          if (data_be_i[k]) mem[data_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
        end
      end
      data_ram_q <= mem[data_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) oor_q <= 1'b0;
    else         oor_q <= oor_q | (instr_hs & ~instr_in) | (data_hs & ~data_in);
  end

  assign oor_o = oor_q;

  fpga_obi_ram_rsp #(.READ_LAT(READ_LAT)) u_instr_rsp (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .hs_i     (instr_hs),
    .oor_i    (~instr_in),
    .ram_q_i  (instr_ram_q),
    .rvalid_o (instr_rvalid_o),
    .rdata_o  (instr_rdata_o)
  );

  fpga_obi_ram_rsp #(.READ_LAT(READ_LAT)) u_data_rsp (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .hs_i     (data_hs),
    .oor_i    (~data_in),
    .ram_q_i  (data_ram_q),
    .rvalid_o (data_rvalid_o),
    .rdata_o  (data_rdata_o)
  );

endmodule
